ysyx_22050550_ifu: RTL and testbench

YSYX_22050550_IFU -- requirements
Module: ysyx_22050550_IFU

---
 rtl/ysyx_22050550_ifu_pkg.sv | 20 ++
 rtl/ysyx_22050550_ifu_reg.sv | 28 ++
 rtl/ysyx_22050550_ifu.sv | 139 +++++++++++++
 tb/tb_ysyx_22050550_ifu.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_ifu_pkg.sv
// rtl/ysyx_22050550_ifu_pkg.sv - shared widths, reset PC and FSM encodings for the fetch unit
package ysyx_22050550_ifu_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;

    // Instructions are word aligned; redirect targets are coerced onto a word.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050550_ifu_reg.sv
// rtl/ysyx_22050550_ifu_reg.sv - enabled register with synchronous reset value
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, loads RESET_VAL
//   wen  - write enable
//   din  - next value
//   dout - registered value
module ysyx_22050550_ifu_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_22050550_ifu.sv
// rtl/ysyx_22050550_ifu.sv - instruction fetch unit: one outstanding fetch, redirect with response kill
//
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  - fetch request toward instruction memory
//   imem_rsp_valid, imem_rsp_data    - instruction returned by memory
//   out_valid/ready, if_pc, if_inst  - held instruction toward the IF/ID register
//   redirect_valid, redirect_pc      - branch/jump/exception redirect
module ysyx_22050550_ifu
    import ysyx_22050550_ifu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

    ifu_state_e state;
    ifu_state_e state_next;
    // Set when the in-flight request belongs to a path abandoned by a redirect;
    // its response must be swallowed instead of presented downstream.
    logic kill;
    logic kill_next;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_din;
    logic            pc_wen;
    logic            cap_wen;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
        end
    end

    // Next-state logic; redirect outranks every other event in each state
    always_comb begin
        state_next = state;
        kill_next  = kill;
        case (state)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_next = S_WAIT;
                    // Request leaves with the old PC while the redirect lands:
                    // its response is stale.
                    kill_next  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = (kill || redirect_valid) ? S_REQ : S_HOLD;
                    kill_next  = 1'b0;
                end else if (redirect_valid) begin
                    kill_next  = 1'b1;
                end
            end
            S_HOLD: begin
                // A coincident out_ready handshake is treated as delivered.
                if (redirect_valid || out_ready) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
                kill_next  = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = 1'b0;
        out_valid      = 1'b0;
        case (state)
            S_REQ:   imem_req_valid = 1'b1;
            S_HOLD:  out_valid      = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr = pc;

    // PC advances only after the held instruction is consumed; wraps at 2^64.
    assign pc_wen = redirect_valid || (state == S_HOLD && out_ready);
    assign pc_din = redirect_valid ? align_pc(redirect_pc) : pc + 64'd4;

    // Only a live (not killed, not being redirected) response is captured.
    assign cap_wen = (state == S_WAIT) && imem_rsp_valid && !kill && !redirect_valid;

    ysyx_22050550_ifu_reg #(
        .WIDTH    (PC_W),
        .RESET_VAL(RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .wen (pc_wen),
        .din (pc_din),
        .dout(pc)
    );

    ysyx_22050550_ifu_reg #(
        .WIDTH    (PC_W),
        .RESET_VAL(RESET_PC)
    ) u_if_pc_reg (
        .clk (clk),
        .rst (rst),
        .wen (cap_wen),
        .din (pc),
        .dout(if_pc)
    );

    ysyx_22050550_ifu_reg #(
        .WIDTH    (INST_W),
        .RESET_VAL('0)
    ) u_if_inst_reg (
        .clk (clk),
        .rst (rst),
        .wen (cap_wen),
        .din (imem_rsp_data),
        .dout(if_inst)
    );

endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// tb/tb_ysyx_22050550_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_22050550_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;

    int checks   = 0;
    int failures = 0;

    int          grant_req  = 0;
    int          grant_used = 0;
    int          mem_lat    = 0;
    bit          pending    = 1'b0;
    int          wait_cnt   = 0;
    logic [63:0] paddr      = 64'h0;

    logic [63:0] addr_q[$];
    logic [95:0] xfer_q[$];

    assign imem_req_ready = (grant_req != grant_used);

    always #5 clk = ~clk;

    ysyx_22050550_ifu #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        if (a == RST_PC) return 32'h0000_0413;
        return {a[31:2], 2'b11} ^ 32'h5a00_0000;
    endfunction

    // Memory model plus request/transfer scoreboard. Samples just before the
    // rising edge, updates the response just after it.
    task automatic memory_and_monitor();
        logic        s_rst, s_acc, s_rsp;
        logic [63:0] s_addr;
        logic [63:0] e_addr;
        logic [95:0] e_xfer;
        forever begin
            @(negedge clk);
            #4;
            s_rst  = rst;
            s_acc  = !rst && imem_req_valid && imem_req_ready;
            s_rsp  = imem_rsp_valid;
            s_addr = imem_addr;
            if (s_acc) begin
                checks++;
                if (pending) begin
                    failures++;
                    $display("FAIL single_outstanding: request at %h while one pending", s_addr);
                end
                checks++;
                if (addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL req_addr: unexpected request at %h, none expected", s_addr);
                end else begin
                    e_addr = addr_q.pop_front();
                    if (s_addr !== e_addr) begin
                        failures++;
                        $display("FAIL req_addr: got %h expected %h", s_addr, e_addr);
                    end
                end
            end
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (xfer_q.size() == 0) begin
                    failures++;
                    $display("FAIL transfer: unexpected pc=%h inst=%h", if_pc, if_inst);
                end else begin
                    e_xfer = xfer_q.pop_front();
                    if ({if_pc, if_inst} !== e_xfer) begin
                        failures++;
                        $display("FAIL transfer: got pc=%h inst=%h expected pc=%h inst=%h",
                                 if_pc, if_inst, e_xfer[95:32], e_xfer[31:0]);
                    end
                end
            end
            #2;
            if (s_rst) begin
                pending = 1'b0;
            end else begin
                if (pending && s_rsp) pending = 1'b0;
                else if (pending && wait_cnt != 0) wait_cnt--;
                if (s_acc) begin
                    pending  = 1'b1;
                    paddr    = s_addr;
                    wait_cnt = mem_lat;
                    grant_used++;
                end
            end
            imem_rsp_valid = pending && (wait_cnt == 0);
            imem_rsp_data  = pending ? inst_of(paddr) : 32'h0;
        end
    endtask

    task automatic push_fetch(input logic [63:0] a);
        addr_q.push_back(a);
        xfer_q.push_back({a, inst_of(a)});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && xfer_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (xfer_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d transfers outstanding, expected 0", name, xfer_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL rst_req_valid: got %b expected 1", imem_req_valid); end
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RST_PC); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (if_pc !== RST_PC) begin failures++; $display("FAIL rst_if_pc: got %h expected %h", if_pc, RST_PC); end
        checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL rst_if_inst: got %h expected 0", if_inst); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem_lat = 0;
        push_fetch(RST_PC);
        grant_req++;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if ({imem_req_valid, out_valid} !== 2'b00) begin failures++; $display("FAIL basic_wait: got req=%b out=%b expected 0 0", imem_req_valid, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        checks++; if (if_pc !== RST_PC) begin failures++; $display("FAIL basic_if_pc: got %h expected %h", if_pc, RST_PC); end
        checks++; if (if_inst !== 32'h0000_0413) begin failures++; $display("FAIL basic_if_inst: got %h expected 00000413", if_inst); end
        @(negedge clk);
        checks++; if (imem_addr !== 64'h8000_0004) begin failures++; $display("FAIL basic_next_addr: got %h expected 80000004", imem_addr); end
        checks++; if ({imem_req_valid, out_valid} !== 2'b10) begin failures++; $display("FAIL basic_back_req: got req=%b out=%b expected 1 0", imem_req_valid, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        push_fetch(64'h8000_0004);
        grant_req++;
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, imem_req_valid, if_pc, if_inst} !== {2'b10, 64'h8000_0004, inst_of(64'h8000_0004)}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got out=%b req=%b pc=%h inst=%h expected 1 0 %h %h",
                         i, out_valid, imem_req_valid, if_pc, if_inst, 64'h8000_0004, inst_of(64'h8000_0004));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release: got out_valid=%b expected 0", out_valid); end
        checks++; if (imem_addr !== 64'h8000_0008) begin failures++; $display("FAIL stall_next_addr: got %h expected 80000008", imem_addr); end
        checks++; if (xfer_q.size() != 0) begin failures++; $display("FAIL stall_one_xfer: got %0d left expected 0", xfer_q.size()); end
    endtask

    task automatic test_redirect_wait();
        @(negedge clk);
        mem_lat = 2;
        addr_q.push_back(64'h8000_0008);
        push_fetch(64'h8000_0100);
        grant_req++;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 64'h8000_0100) begin failures++; $display("FAIL rw_aligned_pc: got %h expected 80000100", imem_addr); end
        @(negedge clk);
        checks++; if ({imem_req_valid, out_valid} !== 2'b00) begin failures++; $display("FAIL rw_still_wait: got req=%b out=%b expected 0 0", imem_req_valid, out_valid); end
        @(negedge clk);
        checks++; if ({imem_req_valid, out_valid} !== 2'b10) begin failures++; $display("FAIL rw_dropped: got req=%b out=%b expected 1 0", imem_req_valid, out_valid); end
        mem_lat = 0;
        grant_req++;
        out_ready = 1'b1;
        drain("rw");
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_accept();
        @(negedge clk);
        mem_lat = 0;
        addr_q.push_back(64'h8000_0104);
        push_fetch(64'h8000_0200);
        grant_req++;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL ra_in_wait: got req=%b expected 0", imem_req_valid); end
        @(negedge clk);
        checks++; if ({imem_req_valid, out_valid, imem_addr} !== {2'b10, 64'h8000_0200}) begin
            failures++; $display("FAIL ra_dropped: got req=%b out=%b addr=%h expected 1 0 80000200", imem_req_valid, out_valid, imem_addr);
        end
        grant_req++;
        out_ready = 1'b1;
        drain("ra");
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        @(negedge clk);
        push_fetch(64'h8000_0204);
        push_fetch(64'h8000_0300);
        grant_req++;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rh_hold: got out_valid=%b expected 1", out_valid); end
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0301;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if ({imem_req_valid, out_valid, imem_addr} !== {2'b10, 64'h8000_0300}) begin
            failures++; $display("FAIL rh_redirect: got req=%b out=%b addr=%h expected 1 0 80000300", imem_req_valid, out_valid, imem_addr);
        end
        grant_req++;
        drain("rh");
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if ({imem_req_valid, imem_addr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
            failures++; $display("FAIL wrap_redirect_req: got req=%b addr=%h expected 1 fffffffffffffffc", imem_req_valid, imem_addr);
        end
        push_fetch(64'hFFFF_FFFF_FFFF_FFFC);
        grant_req++;
        out_ready = 1'b1;
        drain("wrap");
        out_ready = 1'b0;
        checks++; if (imem_addr !== 64'h0) begin failures++; $display("FAIL wrap_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_lat = 2;
        addr_q.push_back(64'h0);
        grant_req++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({imem_req_valid, out_valid, imem_addr, if_inst} !== {2'b10, RST_PC, 32'h0}) begin
            failures++; $display("FAIL midrst_state: got req=%b out=%b addr=%h inst=%h expected 1 0 %h 0", imem_req_valid, out_valid, imem_addr, if_inst, RST_PC);
        end
        mem_lat = 0;
        push_fetch(RST_PC);
        grant_req++;
        out_ready = 1'b1;
        drain("midrst");
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        mem_lat = 0;
        push_fetch(64'h8000_0004);
        push_fetch(64'h8000_0008);
        push_fetch(64'h8000_000C);
        grant_req += 3;
        out_ready = 1'b1;
        n = 0;
        while (xfer_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checks++; if (n != 9) begin failures++; $display("FAIL b2b_cycles: got %0d cycles expected 9", n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            memory_and_monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_accept();
        test_redirect_hold();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (addr_q.size() != 0 || xfer_q.size() != 0) begin
            failures++;
            $display("FAIL leftovers: got %0d requests %0d transfers expected 0 0", addr_q.size(), xfer_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
